// File: rtl/uart_alu_top.sv
// UART-fronted ALU: three received bytes (A, B, opcode) produce one result byte
// transmitted back on o_tx. Baud ticks are 16x oversampled and shared by RX and TX.
module uart_alu_top #(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int NB_STATE  = 2,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 19200,
    parameter int NB_OP     = 6
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_data_rx,
    output logic o_tx
);
    localparam int M  = (CLK_FREQ + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CW-1:0]   M_LAST = CW'(M - 1);
    localparam logic [SW-1:0]   S_MID  = SW'(7);
    localparam logic [SW-1:0]   S_BIT  = SW'(15);
    localparam logic [SW-1:0]   S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0]   N_LAST = NW'(DBIT - 1);
    localparam logic [DBIT-1:0] SH_LIM = DBIT'(DBIT);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    typedef enum logic [NB_STATE-1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [NB_STATE-1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {IF_WAIT_A, IF_WAIT_B, IF_WAIT_OP, IF_SEND} if_state_t;

    logic [CW-1:0]   baud_q, baud_d;
    logic            tick;
    logic            rx_meta_q, rx_sync_q;

    rx_state_t       rx_state_q, rx_state_d;
    logic [SW-1:0]   rx_s_q, rx_s_d;
    logic [NW-1:0]   rx_n_q, rx_n_d;
    logic [DBIT-1:0] rx_b_q, rx_b_d;
    logic            rx_done;

    if_state_t       if_state_q, if_state_d;
    logic [DBIT-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
    logic [NB_OP-1:0] op_q, op_d;
    logic            tx_start_q, tx_start_d;
    logic signed [DBIT-1:0] a_s;

    tx_state_t       tx_state_q, tx_state_d;
    logic [SW-1:0]   tx_s_q, tx_s_d;
    logic [NW-1:0]   tx_n_q, tx_n_d;
    logic [DBIT-1:0] tx_b_q, tx_b_d;
    logic            tx_q, tx_d, tx_done;

    always_comb begin
        tick   = (baud_q == M_LAST);
        baud_d = tick ? '0 : baud_q + CW'(1);
    end

    // Receiver; a start bit that is gone by mid-bit is treated as a glitch.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) begin
                rx_state_d = RX_START;
                rx_s_d     = '0;
            end
            RX_START: if (tick) begin
                if (rx_s_q == S_MID) begin
                    rx_s_d     = '0;
                    rx_n_d     = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_s_d = rx_s_q + SW'(1);
                end
            end
            RX_DATA: if (tick) begin
                if (rx_s_q == S_BIT) begin
                    rx_s_d = '0;
                    rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
                    if (rx_n_q == N_LAST) rx_state_d = RX_STOP;
                    else                  rx_n_d     = rx_n_q + NW'(1);
                end else begin
                    rx_s_d = rx_s_q + SW'(1);
                end
            end
            RX_STOP: if (tick) begin
                if (rx_s_q == S_STOP) begin
                    rx_done    = rx_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_s_d = rx_s_q + SW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        if_state_d = if_state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        tx_start_d = 1'b0;
        case (if_state_q)
            IF_WAIT_A:  if (rx_done) begin a_d = rx_b_q; if_state_d = IF_WAIT_B; end
            IF_WAIT_B:  if (rx_done) begin b_d = rx_b_q; if_state_d = IF_WAIT_OP; end
            IF_WAIT_OP: if (rx_done) begin op_d = rx_b_q[NB_OP-1:0]; if_state_d = IF_SEND; end
            IF_SEND: begin
                res_d      = alu_res;
                tx_start_d = 1'b1;
                if_state_d = IF_WAIT_A;
            end
            default: if_state_d = IF_WAIT_A;
        endcase
    end

    assign a_s = a_q;

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD: alu_res = a_q + b_q;
            OP_SUB: alu_res = a_q - b_q;
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_SRA: alu_res = (b_q >= SH_LIM) ? {DBIT{a_q[DBIT-1]}} : $unsigned(a_s >>> b_q);
            OP_SRL: alu_res = (b_q >= SH_LIM) ? '0 : a_q >> b_q;
            default: alu_res = '0;
        endcase
    end

    // Transmitter; o_tx is registered from the next state so it never glitches.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        tx_done    = 1'b0;
        tx_d       = 1'b1;
        case (tx_state_q)
            TX_IDLE: if (tx_start_q) begin
                tx_state_d = TX_START;
                tx_s_d     = '0;
                tx_b_d     = res_q;
            end
            TX_START: if (tick) begin
                if (tx_s_q == S_BIT) begin
                    tx_state_d = TX_DATA;
                    tx_s_d     = '0;
                    tx_n_d     = '0;
                end else begin
                    tx_s_d = tx_s_q + SW'(1);
                end
            end
            TX_DATA: if (tick) begin
                if (tx_s_q == S_BIT) begin
                    tx_s_d = '0;
                    tx_b_d = tx_b_q >> 1;
                    if (tx_n_q == N_LAST) tx_state_d = TX_STOP;
                    else                  tx_n_d     = tx_n_q + NW'(1);
                end else begin
                    tx_s_d = tx_s_q + SW'(1);
                end
            end
            TX_STOP: if (tick) begin
                if (tx_s_q == S_STOP) tx_done = 1'b1;
                else                  tx_s_d  = tx_s_q + SW'(1);
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_done) tx_state_d = TX_IDLE;
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_b_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            baud_q     <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
            if_state_q <= IF_WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            tx_start_q <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            baud_q     <= baud_d;
            rx_meta_q  <= i_data_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_n_q     <= rx_n_d;
            rx_b_q     <= rx_b_d;
            if_state_q <= if_state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            tx_start_q <= tx_start_d;
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_b_q     <= tx_b_d;
            tx_q       <= tx_d;
        end
    end

    assign o_tx = tx_q;

endmodule

// File: tb/tb_uart_alu_top.sv
// Bench for uart_alu_top: serial A/B/OP transactions against an arithmetic model,
// with a line monitor that decodes o_tx frames and checks their bit timing.
`timescale 1ns/1ps
module tb_uart_alu_top;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 15625;
    localparam int M        = 4;          // round(1e6 / (15625*16))
    localparam int BT       = 16 * M;     // clocks per bit
    localparam int M_DEF    = 163;        // round(50e6 / (19200*16))
    localparam int WIN      = 10 * BT - M;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx, tx_def;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int frames = 0;
    int last_fall = -1;
    int exp_q[$];
    bit smp [WIN];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_alu_top #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_data_rx(rx), .o_tx(tx));

    uart_alu_top dut_def (
        .i_clock(clk), .i_reset(rst_n), .i_data_rx(1'b1), .o_tx(tx_def));

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int alu_ref(input int a, input int b, input int op);
        int sa;
        case (op % 64)
            'h20: return (a + b) % 256;
            'h22: return (a - b + 256) % 256;
            'h24: return a & b;
            'h25: return a | b;
            'h26: return a ^ b;
            'h27: return 255 - (a | b);
            'h03: begin
                if (b >= 8) return (a >= 128) ? 255 : 0;
                sa = (a >= 128) ? a - 256 : a;
                sa = sa >>> b;
                return sa & 255;
            end
            'h02: return (b >= 8) ? 0 : a / (1 << b);
            default: return 0;
        endcase
    endfunction

    task automatic hold(input bit v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input int v, input bit good_stop);
        hold(1'b0, BT);
        for (int i = 0; i < 8; i++) hold(v[i], BT);
        if (good_stop) begin
            hold(1'b1, BT + 2);
        end else begin
            hold(1'b0, BT / 2 + 16);
            hold(1'b1, 2 * BT);
        end
    endtask

    task automatic send_txn(input int a, input int b, input int op);
        exp_q.push_back(alu_ref(a, b, op));
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(op, 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 12 * BT && exp_q.size() != 0; k++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // Line monitor: captures each o_tx frame sample by sample.
    initial begin : monitor
        int data, z, first_rise, prev_t, nbad, expv;
        int bv [10];
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                last_fall = cyc;
                smp[0] = 1'b0;
                for (int k = 1; k < WIN; k++) begin
                    @(negedge clk);
                    smp[k] = tx;
                end
                for (int i = 0; i < 10; i++) bv[i] = int'(smp[i * BT + BT / 2 - M / 2]);
                data = 0;
                for (int i = 0; i < 8; i++) data = data | (bv[i + 1] << i);
                z = 10;
                for (int i = 9; i >= 0; i--) if (bv[i] == 1) z = i;
                first_rise = -1;
                prev_t = 0;
                nbad = 0;
                for (int k = 1; k < WIN; k++) begin
                    if (smp[k] != smp[k - 1]) begin
                        if (first_rise < 0) first_rise = k;
                        else if ((k - prev_t) % BT != 0) nbad++;
                        prev_t = k;
                    end
                end
                frames++;
                check("tx_stop_bit", bv[9], 1);
                check("tx_bit_grid", nbad, 0);
                check("tx_start_len", int'(first_rise >= z * BT - M + 1 && first_rise <= z * BT), 1);
                check("tx_frame_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    expv = exp_q.pop_front();
                    check("tx_data", data, expv);
                end
            end
        end
    end

    initial begin : main
        int t0, period, a, b, op, sel;
        int dir_a [10] = '{'h05, 'hFF, 'h80, 'h80, 'h80, 'h0F, 'h0F, 'h0F, 'h0F, 'h0F};
        int dir_b [10] = '{'h07, 'h01, 'h01, 'h01, 'h09, 'hF0, 'hF0, 'hF0, 'hF0, 'hF0};
        int dir_o [10] = '{'h22, 'h20, 'h03, 'h02, 'h03, 'h3F, 'h24, 'h25, 'h26, 'h27};
        int ops [9] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h03, 'h02, -1};
        int ntxn;

        ntxn = 0;
        repeat (5) @(negedge clk);
        check("rst_tx_idle", tx, 1);
        check("rst_baud_cnt", int'(dut.baud_q), 0);
        rst_n = 1'b1;

        t0 = -1; period = -1;
        for (int k = 0; k < 2 * M_DEF + 10 && period < 0; k++) begin
            @(negedge clk);
            if (dut_def.tick) begin
                if (t0 < 0) t0 = cyc;
                else period = cyc - t0;
            end
        end
        check("tick_period_default", period, M_DEF);

        t0 = -1; period = -1;
        for (int k = 0; k < 4 * M + 10 && period < 0; k++) begin
            @(negedge clk);
            if (dut.tick) begin
                if (t0 < 0) t0 = cyc;
                else period = cyc - t0;
            end
        end
        check("tick_period_bench", period, M);

        // ADD with result latency measured against the OP frame
        exp_q.push_back(alu_ref('h55, 'h01, 'h20));
        send_byte('h55, 1'b1);
        send_byte('h01, 1'b1);
        t0 = cyc;
        send_byte('h20, 1'b1);
        for (int k = 0; k < BT && last_fall <= t0; k++) @(negedge clk);
        check("result_latency", int'(last_fall > t0 && last_fall <= t0 + 11 * BT), 1);
        ntxn++;

        for (int i = 0; i < 10; i++) begin
            send_txn(dir_a[i], dir_b[i], dir_o[i]);
            ntxn++;
        end
        drain("drain_directed");

        // Reset in the middle of B's data bits
        send_byte('h11, 1'b1);
        hold(1'b0, BT);
        hold(1'b1, BT);
        hold(1'b0, BT);
        hold(1'b1, BT / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst_mid_tx_idle", tx, 1);
        end
        rst_n = 1'b1;
        hold(1'b1, BT);
        send_txn('h30, 'h12, 'h22);
        ntxn++;

        // Framing error between A and B
        exp_q.push_back(alu_ref('h9C, 'h23, 'h26));
        send_byte('h9C, 1'b1);
        send_byte('h5A, 1'b0);
        send_byte('h23, 1'b1);
        send_byte('h26, 1'b1);
        ntxn++;

        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
            sel = int'($urandom_range(0, 8));
            op = (ops[sel] < 0) ? int'($urandom_range(0, 255)) : ops[sel] + 64 * int'($urandom_range(0, 3));
            send_txn(a, b, op);
            ntxn++;
        end
        drain("drain_random");

        check("frame_count", frames, ntxn);
        check("final_tx_idle", tx, 1);
        check("default_tx_idle", tx_def, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_alu_top.md
UART_ALU_TOP -- requirements
Module: uart_alu_top

Interface
REQ-001 Parameter DBIT, default 8: data bits per UART frame and ALU operand/result width.
REQ-002 Parameter SB_TICK, default 16: oversampling ticks spent in the stop bit.
REQ-003 Parameter NB_STATE, default 2: width of each UART FSM state register.
REQ-004 Parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz.
REQ-005 Parameter BAUD_RATE, default 19200: serial bit rate in bits per second.
REQ-006 Parameter NB_OP, default 6: opcode width, taken from the low bits of the third received byte.
REQ-007 Port i_clock, input, 1: single system clock; all logic is synchronous to its rising edge.
REQ-008 Port i_reset, input, 1: synchronous, active-low reset.
REQ-009 Port i_data_rx, input, 1: UART serial input, idle high.
REQ-010 Port o_tx, output, 1: UART serial output, idle high.

Function
REQ-011 The baud tick generator SHALL count 0..M-1 with M = round(CLK_FREQ/(BAUD_RATE*16)), which is 163 at the defaults.
REQ-012 The baud tick generator SHALL emit a one-cycle tick when the count equals M-1 and then wrap the count to 0; the tick runs continuously.
REQ-013 The RX FSM SHALL have the states IDLE, START, DATA and STOP; it leaves IDLE when it samples i_data_rx low.
REQ-014 In START the RX FSM SHALL count 7 ticks to reach mid-bit and then move to DATA.
REQ-015 In DATA the RX FSM SHALL sample every 16th tick and shift each sample into the MSB of the shift register, so data is received LSB first, DBIT bits.
REQ-016 In STOP the RX FSM SHALL wait SB_TICK ticks and then sample the line; a 1 pulses rx_done for one cycle, a 0 discards the byte as a framing error; either way it returns to IDLE.
REQ-017 A two-flop synchronizer SHALL precede the RX sampling of i_data_rx.
REQ-018 The interface FSM SHALL have the states WAIT_A, WAIT_B, WAIT_OP and SEND.
REQ-019 On each rx_done the interface FSM SHALL latch the byte into A, then B, then OP, in that order.
REQ-020 After OP is latched, the interface FSM SHALL register the ALU result one cycle later, pulse tx_start for one cycle, and return to WAIT_A.
REQ-021 The ALU SHALL be combinational over A, B (DBIT bits) and OP[NB_OP-1:0], producing a DBIT-bit result that wraps modulo 2^DBIT.
REQ-022 ALU opcode encodings: ADD 100000 = A+B; SUB 100010 = A-B; AND 100100; OR 100101; XOR 100110; NOR 100111; SRA 000011 = A arithmetic-shifted right by B; SRL 000010 = A logical-shifted right by B.
REQ-023 Any other opcode SHALL yield a result of 0.
REQ-024 For SRA and SRL, a shift amount B >= DBIT SHALL yield all sign bits (SRA) or 0 (SRL).
REQ-025 The TX FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-026 On tx_start in IDLE, the TX FSM SHALL load the byte and drive o_tx = 0 for 16 ticks.
REQ-027 The TX FSM SHALL then send DBIT data bits LSB first, 16 ticks each, followed by o_tx = 1 for SB_TICK ticks.
REQ-028 At the end of the stop bit the TX FSM SHALL pulse tx_done for one cycle and return to IDLE.
REQ-029 A tx_start that arrives while the TX FSM is not in IDLE SHALL be ignored, and that result is lost.
REQ-030 o_tx SHALL be driven from a register, with no glitches.
REQ-031 RX SHALL keep operating while TX is busy, so a new A/B/OP sequence may be received during transmission.

Reset
REQ-032 While i_reset = 0 at a clock edge, the design SHALL clear the baud counter to 0.
REQ-033 Under reset, the RX, TX and interface FSMs SHALL return to IDLE or WAIT_A, and all tick and bit counters, shift registers, A, B, OP and the result register SHALL clear to 0.
REQ-034 Under reset, o_tx SHALL be 1 and no tx_start or rx_done SHALL be pulsed.
REQ-035 A reset in the middle of a frame SHALL abort the frame; a partially received A/B/OP sequence SHALL be discarded and reception restarts at A.

Verification
REQ-036 Frames at 19200 baud: A = 0x55, B = 0x01, OP = 0x20 (ADD) -> o_tx emits one frame with data 0x56 within 1 bit time after the OP stop bit.
REQ-037 A = 0x05, B = 0x07, OP = 0x22 (SUB) -> 0xFE; A = 0xFF, B = 0x01, ADD -> 0x00 (wrap-around).
REQ-038 A = 0x80, B = 0x01: OP = 0x03 (SRA) -> 0xC0, OP = 0x02 (SRL) -> 0x40; A = 0x80, B = 0x09, SRA -> 0xFF.
REQ-039 A = 0x0F, B = 0xF0, OP = 0x3F (undefined) -> 0x00; AND, OR, XOR and NOR on the same operands -> 0x00, 0xFF, 0xFF and 0x00.
REQ-040 Assert reset during the data bits of B, then send a full A/B/OP sequence -> the result uses only post-reset bytes, and o_tx stays 1 during reset.
REQ-041 Send a frame whose stop bit is 0 -> the byte is not counted; the next three valid bytes form A/B/OP; measured tick period = 163 clocks and o_tx bit period = 16*163 clocks.
